// File: rtl/bf_pkg.sv
// Shared TinyBF definitions: UART state encoding and the baud divider arithmetic
// used by both the receiver and the transmitter.
package bf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  function automatic int uart_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int uart_half(input int clk_freq, input int baud_rate);
    return uart_div(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/bf_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs (rx, start, halt).
// The reset value lets an idle-high line come out of reset already idle.
module bf_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bf_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection, framing-error
// and overrun flags, presenting bytes over a valid/ready handshake.
module bf_uart_rx
  import bf_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 38400
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int DIV   = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF  = uart_half(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rx_s;

  bf_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (rx_i),
    .q   (rx_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      // NOTE: a load in ST_STOP below assigns valid_o later in this block and
      // wins over this clear, so accept-and-load in one cycle keeps valid high.
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state  <= ST_START;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
              idx   <= '0;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              // Leave at mid-stop-bit so a back-to-back start edge is not missed.
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              if (!valid_o || ready_i) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_uart_rx.sv
// Scoreboard bench for bf_uart_rx: a fast instance (DIV=16) for the directed
// scenarios and a default-parameter instance (DIV=1302) for the reset scenario.
module tb_bf_uart_rx;

  localparam int DIV_F = 16;
  localparam int DIV_D = 1302;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_f, rx_f, ready_f, valid_f, fe_f, ov_f, busy_f;
  logic [7:0] data_f;
  logic       rst_d, rx_d, ready_d, valid_d, fe_d, ov_d, busy_d;
  logic [7:0] data_d;

  bf_uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut_fast (
    .clk_i       (clk),
    .rst_i       (rst_f),
    .rx_i        (rx_f),
    .data_o      (data_f),
    .valid_o     (valid_f),
    .ready_i     (ready_f),
    .frame_err_o (fe_f),
    .overrun_o   (ov_f),
    .busy_o      (busy_f)
  );

  bf_uart_rx dut_def (
    .clk_i       (clk),
    .rst_i       (rst_d),
    .rx_i        (rx_d),
    .data_o      (data_d),
    .valid_o     (valid_d),
    .ready_i     (ready_d),
    .frame_err_o (fe_d),
    .overrun_o   (ov_d),
    .busy_o      (busy_d)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_f[$];
  logic [7:0] exp_d[$];
  int rise_f, rises_f, hi_f, fe_cnt_f, ov_cnt_f;
  int rises_d, fe_cnt_d, ov_cnt_d;
  logic vq_f = 1'b0;
  logic vq_d = 1'b0;
  int start_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every accepted byte; tally pulses and valid activity.
  always @(negedge clk) begin
    if (!rst_f) begin
      if (valid_f && !vq_f) begin
        rise_f = cyc;
        rises_f++;
      end
      if (valid_f) hi_f++;
      if (fe_f) fe_cnt_f++;
      if (ov_f) ov_cnt_f++;
      if (valid_f && ready_f) begin
        if (exp_f.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fast_unexpected_byte: got %0h expected none", data_f);
        end else begin
          check("fast_data", {24'd0, data_f}, {24'd0, exp_f.pop_front()});
        end
      end
    end
    vq_f = valid_f;
  end

  always @(negedge clk) begin
    if (!rst_d) begin
      if (valid_d && !vq_d) rises_d++;
      if (fe_d) fe_cnt_d++;
      if (ov_d) ov_cnt_d++;
      if (valid_d && ready_d) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL def_unexpected_byte: got %0h expected none", data_d);
        end else begin
          check("def_data", {24'd0, data_d}, {24'd0, exp_d.pop_front()});
        end
      end
    end
    vq_d = valid_d;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_d = v;
    else     rx_f = v;
  endtask

  task automatic clear_f();
    rises_f = 0; hi_f = 0; fe_cnt_f = 0; ov_cnt_f = 0;
  endtask

  // Drives one 8N1 frame; abort_bit >= 0 pulses reset at mid data bit abort_bit.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop,
                            input int div, input int abort_bit);
    drive(sel, 1'b0);
    start_cyc = cyc;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      if (i == abort_bit) begin
        tick(div / 2);
        check("busy_mid_frame", {31'd0, sel ? busy_d : busy_f}, 32'd1);
        if (sel) begin rst_d = 1'b1; rx_d = 1'b1; end
        else     begin rst_f = 1'b1; rx_f = 1'b1; end
        tick(1);
        if (sel) rst_d = 1'b0;
        else     rst_f = 1'b0;
        return;
      end
      tick(div);
    end
    drive(sel, stop);
    tick(div);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_f = 1'b1; rst_d = 1'b1; rx_f = 1'b1; rx_d = 1'b1;
    ready_f = 1'b1; ready_d = 1'b0;
    clear_f();
    rises_d = 0; fe_cnt_d = 0; ov_cnt_d = 0;
    tick(3);
    rst_f = 1'b0; rst_d = 1'b0;
    check("reset_data",  {24'd0, data_f}, 32'd0);
    check("reset_valid", {31'd0, valid_f}, 32'd0);
    check("reset_fe",    {31'd0, fe_f}, 32'd0);
    check("reset_ov",    {31'd0, ov_f}, 32'd0);
    check("reset_busy",  {31'd0, busy_f}, 32'd0);
    tick(4);

    // Single byte: stop sample at t0+152 = start+155 (t0 is start+3 after the synchronizer).
    clear_f();
    exp_f.push_back(8'h55);
    send_frame(1'b0, 8'h55, 1'b1, DIV_F, -1);
    tick(2);
    check("single_rise_cycle", rise_f - start_cyc, 32'd155);
    check("single_valid_width", hi_f, 32'd1);
    check("single_rises", rises_f, 32'd1);
    check("single_fe", fe_cnt_f, 32'd0);
    check("single_ov", ov_cnt_f, 32'd0);

    // Start glitch: 4 low cycles; start sample at start+11 sees high.
    clear_f();
    rx_f = 1'b0;
    tick(4);
    rx_f = 1'b1;
    tick(1);
    check("glitch_busy_high", {31'd0, busy_f}, 32'd1);
    tick(7);
    check("glitch_busy_low", {31'd0, busy_f}, 32'd0);
    tick(5);
    check("glitch_no_valid", rises_f, 32'd0);
    check("glitch_no_fe", fe_cnt_f, 32'd0);

    // Framing error, held-low line, then a clean frame.
    clear_f();
    send_frame(1'b0, 8'hA3, 1'b0, DIV_F, -1);
    tick(40);
    check("break_busy", {31'd0, busy_f}, 32'd1);
    check("break_fe_once", fe_cnt_f, 32'd1);
    check("break_no_valid", rises_f, 32'd0);
    rx_f = 1'b1;
    tick(4);
    check("break_exit", {31'd0, busy_f}, 32'd0);
    exp_f.push_back(8'h3C);
    send_frame(1'b0, 8'h3C, 1'b1, DIV_F, -1);
    tick(2);
    check("after_break_rises", rises_f, 32'd1);
    check("after_break_fe", fe_cnt_f, 32'd1);

    // Overrun: second byte dropped while the first is pending.
    clear_f();
    ready_f = 1'b0;
    exp_f.push_back(8'h12);
    send_frame(1'b0, 8'h12, 1'b1, DIV_F, -1);
    send_frame(1'b0, 8'h34, 1'b1, DIV_F, -1);
    tick(2);
    check("overrun_data_held", {24'd0, data_f}, 32'h12);
    check("overrun_valid", {31'd0, valid_f}, 32'd1);
    check("overrun_pulse", ov_cnt_f, 32'd1);
    ready_f = 1'b1;
    tick(1);
    check("overrun_valid_cleared", {31'd0, valid_f}, 32'd0);

    // Accept of 0x12 coincides with the 0x34 stop-sample edge.
    clear_f();
    ready_f = 1'b0;
    exp_f.push_back(8'h12);
    exp_f.push_back(8'h34);
    send_frame(1'b0, 8'h12, 1'b1, DIV_F, -1);
    fork
      send_frame(1'b0, 8'h34, 1'b1, DIV_F, -1);
      begin
        tick(154);
        ready_f = 1'b1;
        tick(1);
        ready_f = 1'b0;
      end
    join
    check("simul_data", {24'd0, data_f}, 32'h34);
    check("simul_valid", {31'd0, valid_f}, 32'd1);
    check("simul_no_ov", ov_cnt_f, 32'd0);
    ready_f = 1'b1;
    tick(2);
    check("simul_drained", {31'd0, valid_f}, 32'd0);

    // Default divider: pending byte, then reset during data bit 3, then 0xC3.
    send_frame(1'b1, 8'h5A, 1'b1, DIV_D, -1);
    tick(2);
    check("def_pending_valid", {31'd0, valid_d}, 32'd1);
    check("def_pending_data", {24'd0, data_d}, 32'h5A);
    send_frame(1'b1, 8'hC3, 1'b1, DIV_D, 3);
    check("rst_mid_data",  {24'd0, data_d}, 32'd0);
    check("rst_mid_valid", {31'd0, valid_d}, 32'd0);
    check("rst_mid_busy",  {31'd0, busy_d}, 32'd0);
    check("rst_mid_fe",    {31'd0, fe_d}, 32'd0);
    check("rst_mid_ov",    {31'd0, ov_d}, 32'd0);
    tick(20);
    ready_d = 1'b1;
    rises_d = 0; fe_cnt_d = 0; ov_cnt_d = 0;
    exp_d.push_back(8'hC3);
    send_frame(1'b1, 8'hC3, 1'b1, DIV_D, -1);
    tick(4);
    check("def_rises", rises_d, 32'd1);
    check("def_fe", fe_cnt_d, 32'd0);
    check("def_ov", ov_cnt_d, 32'd0);

    check("fast_queue_empty", exp_f.size(), 32'd0);
    check("def_queue_empty", exp_d.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_uart_rx.md
# bf_uart_rx

Standalone UART receiver for the TinyBF core: 8N1 frames arrive on the serial input and are presented as bytes over a valid/ready handshake. It serves the Brainfuck `,` input command, and is the receiving counterpart of the core's UART transmitter on `uo[0]`. It samples at mid-bit from a fixed clock divider, rejects start-bit glitches, and flags framing errors and overruns.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD_RATE`, default 38400: serial bit rate.
- Derived: `DIV = CLK_FREQ/BAUD_RATE` (integer floor, 1302 at default); `HALF = DIV/2` (651).
- Counter width is `$clog2(DIV)`.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `rx_i`  in  1  asynchronous serial line; idle high.
- `data_o`  out  8  received byte, held stable while `valid_o` is high.
- `valid_o`  out  1  byte available.
- `ready_i`  in  1  consumer accepts the byte when `valid_o && ready_i`.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun_o`  out  1  one-cycle pulse when a completed byte is dropped.
- `busy_o`  out  1  high when the state is not IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: when `rx_s==0`, go to START and clear the counter.
- START: after HALF cycles, sample `rx_s`.
  - If 0, go to DATA with bit index 0.
  - If 1, return to IDLE. This is glitch rejection: no output activity.
- DATA: every DIV cycles, sample `rx_s` into bit `[idx]`, LSB first. After bit 7, go to STOP.
- STOP: after DIV cycles, sample `rx_s`.
  - If 1: deliver the byte and go to IDLE immediately. This is mid-stop-bit, so the next start edge is detectable with no extra gap.
  - If 0: pulse `frame_err_o`, discard the byte, go to BREAK.
- BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line therefore never triggers repeated false frames.
- Delivery on the cycle of the stop-bit sample:
  - If `valid_o==0`, or `valid_o && ready_i` in that same cycle: load `data_o` and keep or set `valid_o=1`. Accept and load in the same cycle must not lose either byte.
  - If `valid_o && !ready_i`: pulse `overrun_o`. The new byte is dropped and the old `data_o` is retained.
- When `valid_o && ready_i` and no load is occurring, `valid_o` clears on the next edge.
- `data_o` changes only on a load.
- `ready_i` has no effect while `valid_o==0`.

## Timing
- Reset values: `data_o=0`, `valid_o=0`, `frame_err_o=0`, `overrun_o=0`, `busy_o=0`, state IDLE, counter 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame and clears any pending byte. There is no partial delivery.
- Synchronizer latency is 2 cycles from an `rx_i` change to `rx_s`.
- Let t0 be the edge where IDLE sees `rx_s==0`. Sample edges relative to t0:
  - Start bit at t0+HALF.
  - Data bit k at t0+HALF+(k+1)·DIV.
  - Stop bit at t0+HALF+9·DIV.
- `valid_o`, `frame_err_o` and `overrun_o` take effect on the stop-sample edge, so they are visible in the following cycle.
- `busy_o` is high from t0+1 until the edge that returns the block to IDLE.
- Baud error from the integer DIV must be ≤2% at the defaults (1302 vs 1302.08: compliant).

## Structure
- Shared package/include `bf_pkg`:
  - UART state encoding constants (3-bit).
  - `DIV`/`HALF` derivation helper, shared with the transmitter so both ends use identical divider arithmetic.
- One sub-module: `bf_sync2`, the 2-flop synchronizer with a reset value parameter, reusable for `start_i`/`halt_i`.
- Everything else (FSM, counter, shift register, output register) lives in `bf_uart_rx`.

## Test plan
Directed scenarios use CLK_FREQ=16, BAUD_RATE=1 (DIV=16, HALF=8) unless noted.

- **Single byte:** send 0x55 with `ready_i=1` → `data_o=0x55` and `valid_o` high starting at t0+153 for exactly one cycle. `frame_err_o` and `overrun_o` stay 0.
- **Start glitch:** drive `rx_i` low for 4 cycles, then high → `busy_o` returns to 0 after the start sample. No `valid_o`, no `frame_err_o`.
- **Framing error:** send 0xA3 with the stop bit low, holding the line low 40 more cycles → one-cycle `frame_err_o`, `valid_o` stays 0. The state stays BREAK until the line goes high, after which a following 0x3C is received correctly.
- **Overrun:** send 0x12 then 0x34 back-to-back with `ready_i=0` → `data_o` holds 0x12, `overrun_o` pulses once at the second stop sample. Raising `ready_i` clears `valid_o` the next cycle.
- **Simultaneous accept and load:** hold 0x12 pending, then assert `ready_i` exactly on the 0x34 stop-sample cycle → `data_o=0x34`, `valid_o` stays 1, no `overrun_o`.
- **Reset mid-frame:** assert `rst_i` for 1 cycle during data bit 3 → all outputs 0 and IDLE on the next cycle. A subsequent 0xC3 frame is received correctly with the default parameters (DIV=1302).
